tt_um_serial_subtractor: RTL
============================

# tt_um_serial_subtractor

Bit-serial 8-bit subtractor for the TinyTapeout tile, and the inverse-operation counterpart to the team's half-adder tile. It accepts operand bits LSB-first on dedicated inputs, produces one registered difference bit per accepted input bit, and carries a borrow flip-flop between bits. A small state machine frames each word, counts bits, and reports completion, final borrow and a zero flag.

## Interface
- `WIDTH`, 8: bits per word; legal range 2..8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  tile enable; always 1 when powered; ignored.
- `ui_in`  in  8  [0] a_bit (minuend), [1] b_bit (subtrahend), [2] bit_valid, [3] start, [7:4] unused.
- `uo_out`  out  8  [0] diff_bit, [1] borrow, [2] diff_valid, [3] done, [4] busy, [5] zero, [7:6] 0.
- `uio_in`  in  8  unused.
- `uio_out`  out  8  parallel difference (see Configuration), else 0.
- `uio_oe`  out  8  8'hFF with parallel result compiled in, else 8'h00.

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE: start=1 -> RUN; clear borrow, bit counter, result register; zero set to 1. bit_valid ignored.
- RUN, start=0, bit_valid=1: compute d = a ^ b ^ borrow; borrow_next = (~a & b) | (~(a ^ b) & borrow). Register d into diff_bit, borrow_next into borrow, pulse diff_valid; zero &= ~d; shift d into result at position counter; counter++.
- RUN, bit_valid=0: hold all state; diff_valid=0.
- Counter reaches WIDTH (the WIDTH-th accepted bit) -> DONE; done pulses 1 cycle coincident with the final diff_valid.
- start=1 in RUN: abort, restart word exactly as from IDLE; a bit_valid in the same cycle is discarded (start has priority).
- DONE holds diff_bit, borrow, zero, result until next start.
- busy = 1 iff state is RUN.
- Result arithmetic: difference is (A - B) mod 2^WIDTH; final borrow = 1 iff A < B (unsigned).
- Unused ui_in/uio_in bits, ena: no effect.

## Timing
- Reset (rst_n=0 at a rising edge): every uo_out bit 0, uio_out 0, state IDLE, counter 0. uio_oe is constant.
- Latency: bit sampled at edge N appears on diff_bit/diff_valid after edge N, valid for exactly the cycle following N.
- Throughput: one bit per cycle; WIDTH back-to-back bits -> done WIDTH cycles after the first sampled bit's edge.
- start accepted at edge N -> busy=1 after edge N; first bit may be sampled at edge N+1.
- diff_valid and done are single-cycle pulses; never asserted outside RUN-exit/RUN.
- rst_n low mid-word: abort immediately, all outputs as reset; no done.

## Configuration
- `SERSUB_PARALLEL_RESULT_EN` defined: WIDTH-bit result shift register implemented; uio_out[WIDTH-1:0] drives assembled difference (upper bits 0), updating as bits arrive and held in DONE; uio_oe = 8'hFF.
- Undefined: no result register; uio_out = 0, uio_oe = 8'h00; uo_out behaviour unchanged.

## Structure
- Shared package `sersub_pkg`: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), default WIDTH, ui_in/uo_out bit-index constants.
- One sub-module: `sersub_bit_cell`, combinational full subtractor (a, b, bin -> d, bout); state, counter and flags stay in the top.

## Test plan
- start, then A=8'h05, B=8'h03 LSB-first back-to-back -> diff bits 0,1,0,0,0,0,0,0 (8'h02), final borrow 0, zero 0, done one cycle with 8th diff_valid; uio_out=8'h02 with macro.
- A=8'h03, B=8'h05 -> difference 8'hFE, borrow 1, zero 0.
- A=B=8'hA5 -> difference 8'h00, borrow 0, zero 1.
- A=8'h05, B=8'h03 with bit_valid low for 2 cycles between every bit -> same result as scenario 1; state held during gaps; done only after 8th valid bit.
- 3 bits of a word, then start together with bit_valid=1, then full word 8'h10-8'h01 -> first post-start bit discarded, result 8'h0F, borrow 0.
- 4 bits into a word, rst_n=0 one cycle -> all uo_out 0, busy 0; bit_valid without start ignored; fresh start then 8'h00-8'h01 -> 8'hFF, borrow 1.

Source files
------------

// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor tile.
//
// Contents:
//   state_t       - FSM encoding (IDLE=0, RUN=1, DONE=2)
//   SERSUB_WIDTH  - default word width (legal range 2..8)
//   UI_* / UO_*   - bit positions inside ui_in / uo_out
//
// Optional feature macro used by the top: SERSUB_PARALLEL_RESULT_EN.
package sersub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SERSUB_WIDTH = 8;

    // ui_in bit positions
    localparam int UI_A     = 0;
    localparam int UI_B     = 1;
    localparam int UI_VALID = 2;
    localparam int UI_START = 3;

    // uo_out bit positions
    localparam int UO_DIFF   = 0;
    localparam int UO_BORROW = 1;
    localparam int UO_DVALID = 2;
    localparam int UO_DONE   = 3;
    localparam int UO_BUSY   = 4;
    localparam int UO_ZERO   = 5;

endpackage

// File: rtl/sersub_bit_cell.sv
// Combinational one-bit full subtractor: computes a - b - bin.
//
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow in from the less significant bit
//   d    out  difference bit
//   bout out  borrow out to the next more significant bit
module sersub_bit_cell
    import sersub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they are equal and a borrow
    // is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial unsigned subtractor for a TinyTapeout tile.
// Operand bits arrive LSB-first; one registered difference bit is produced
// per accepted input bit, with a borrow flip-flop chaining the bits.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   ena      in   tile enable (ignored)
//   ui_in    in   [0] a_bit, [1] b_bit, [2] bit_valid, [3] start
//   uo_out   out  [0] diff_bit, [1] borrow, [2] diff_valid, [3] done,
//                 [4] busy, [5] zero, [7:6] 0
//   uio_in   in   unused
//   uio_out  out  parallel difference when SERSUB_PARALLEL_RESULT_EN, else 0
//   uio_oe   out  8'hFF when SERSUB_PARALLEL_RESULT_EN, else 8'h00
//
// Configuration macro: SERSUB_PARALLEL_RESULT_EN adds a WIDTH-bit result
// register driven onto uio_out.
//
// Handshake: a bit is consumed on a rising edge where the FSM is in RUN,
// bit_valid=1 and start=0; start always wins and restarts the word.
// diff_valid pulses for the cycle after each consumed bit; done pulses
// together with the diff_valid of the WIDTH-th bit.
module tt_um_serial_subtractor
    import sersub_pkg::*;
#(
    parameter int WIDTH = SERSUB_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       diff_bit_q;
    logic       borrow_q;
    logic       diff_valid_q;
    logic       done_q;
    logic       zero_q;

    logic a_bit, b_bit, bit_valid, start;
    logic cell_d, cell_bout;
    logic accept;
    logic last_bit;

    assign a_bit     = ui_in[UI_A];
    assign b_bit     = ui_in[UI_B];
    assign bit_valid = ui_in[UI_VALID];
    assign start     = ui_in[UI_START];

    wire unused_inputs = &{1'b0, ena, ui_in[7:4], uio_in};

    assign last_bit = (cnt == LAST_IDX);

    sersub_bit_cell u_cell (
        .a    (a_bit),
        .b    (b_bit),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start restarts the word from any state
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (start) begin
                    state_next = ST_RUN;
                end else if (bit_valid) begin
                    accept = 1'b1;
                    if (last_bit) state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= 4'd0;
            diff_bit_q   <= 1'b0;
            borrow_q     <= 1'b0;
            diff_valid_q <= 1'b0;
            done_q       <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            diff_valid_q <= 1'b0;
            done_q       <= 1'b0;
            if (start) begin
                cnt        <= 4'd0;
                diff_bit_q <= 1'b0;
                borrow_q   <= 1'b0;
                zero_q     <= 1'b1;
            end else if (accept) begin
                cnt          <= cnt + 4'd1;
                diff_bit_q   <= cell_d;
                borrow_q     <= cell_bout;
                diff_valid_q <= 1'b1;
                zero_q       <= zero_q & ~cell_d;
                done_q       <= last_bit;
            end
        end
    end

    always_comb begin
        uo_out            = 8'h00;
        uo_out[UO_DIFF]   = diff_bit_q;
        uo_out[UO_BORROW] = borrow_q;
        uo_out[UO_DVALID] = diff_valid_q;
        uo_out[UO_DONE]   = done_q;
        uo_out[UO_BUSY]   = (state == ST_RUN);
        uo_out[UO_ZERO]   = zero_q;
    end

`ifdef SERSUB_PARALLEL_RESULT_EN
    // Bits above WIDTH-1 are never written, so they read as 0 for WIDTH<8.
    logic [7:0] result_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= 8'h00;
        end else if (start) begin
            result_q <= 8'h00;
        end else if (accept) begin
            result_q[cnt[2:0]] <= cell_d;
        end
    end

    assign uio_out = result_q;
    assign uio_oe  = 8'hFF;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule
